// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART frame scheduler.
package uart_pkg;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam logic [7:0] TYPE_STATUS = 8'h01;
  localparam logic [7:0] TYPE_EVENT  = 8'h02;

  localparam int unsigned STATUS_LEN = 10;
  localparam int unsigned EVENT_LEN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } fsm_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Byte serialiser: start bit, 8 data bits LSB first, stop bit; DIVISOR cycles per bit.
module uart_byte_tx #(
  parameter int unsigned DIVISOR = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       tx
);

  localparam int unsigned DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end   = (div_cnt == DW'(DIVISOR - 1));
  // bit_cnt 0 is the start bit, 1..8 data, 9 the stop bit
  assign byte_done = active && bit_end && (bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
    end else if (!active) begin
      if (byte_start) begin
        tx      <= 1'b0;
        shreg   <= byte_data;
        bit_cnt <= '0;
        div_cnt <= '0;
        active  <= 1'b1;
      end
    end else if (bit_end) begin
      div_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Shares one UART TX line between periodic status frames and on-demand event frames.
module uart_frame_sched
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned PERIOD_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] state,
  input  logic [5:0] current_hour,
  input  logic [5:0] current_min,
  input  logic [5:0] current_sec,
  input  logic [5:0] working_hour,
  input  logic [5:0] working_min,
  input  logic [5:0] working_sec,
  input  logic       evt_req,
  input  logic [7:0] evt_code,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       evt_drop
);

  localparam int unsigned DIVISOR    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
  localparam int unsigned PW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [3:0]  STATUS_LAST = 4'(STATUS_LEN - 1);
  localparam logic [3:0]  EVENT_LAST  = 4'(EVENT_LEN - 1);

  fsm_state_t    fsm_q, fsm_d;
  logic [PW-1:0] period_cnt;
  logic          wrap;
  logic          status_pend;
  logic          evt_pend;
  logic [7:0]    evt_code_q;
  logic          evt_accept;
  logic          load_evt, load_sts;
  logic          byte_start, byte_done;
  logic          sent;
  logic [3:0]    idx, last_idx;
  logic [7:0]    frame_buf [STATUS_LEN];
  logic [7:0]    sts_chk;

  // Period timer and status request
  assign wrap = en && (period_cnt == PW'(PERIOD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt  <= '0;
      status_pend <= 1'b0;
    end else begin
      if (!en || wrap) period_cnt <= '0;
      else             period_cnt <= period_cnt + 1'b1;

      if (!en)           status_pend <= 1'b0;
      else if (wrap)     status_pend <= 1'b1;
      else if (load_sts) status_pend <= 1'b0;
    end
  end

  // A request coinciding with LOAD consuming the pending event refills the slot
  assign evt_accept = evt_req && (!evt_pend || load_evt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pend   <= 1'b0;
      evt_code_q <= '0;
      evt_drop   <= 1'b0;
    end else begin
      if (evt_accept)    evt_pend <= 1'b1;
      else if (load_evt) evt_pend <= 1'b0;
      if (evt_accept) evt_code_q <= evt_code;
      evt_drop <= evt_req && !evt_accept;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    load_evt   = 1'b0;
    load_sts   = 1'b0;
    byte_start = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (evt_pend || status_pend) fsm_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        // status_pend may have been withdrawn by en falling while in IDLE
        if (evt_pend) begin
          load_evt = 1'b1;
          fsm_d    = ST_SEND;
        end else if (status_pend) begin
          load_sts = 1'b1;
          fsm_d    = ST_SEND;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        busy       = 1'b1;
        byte_start = !sent;
        if (byte_done) fsm_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx == last_idx) begin
          frame_done = 1'b1;
          fsm_d      = ST_IDLE;
        end else begin
          busy  = 1'b1;
          fsm_d = ST_SEND;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= ST_IDLE;
      idx      <= '0;
      last_idx <= '0;
      sent     <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        ST_LOAD: begin
          idx      <= '0;
          sent     <= 1'b0;
          last_idx <= load_evt ? EVENT_LAST : STATUS_LAST;
        end
        ST_SEND: sent <= 1'b1;
        ST_NEXT: begin
          sent <= 1'b0;
          if (idx != last_idx) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign sts_chk = TYPE_STATUS ^ {5'b0, state}
                 ^ {2'b0, current_hour} ^ {2'b0, current_min} ^ {2'b0, current_sec}
                 ^ {2'b0, working_hour} ^ {2'b0, working_min} ^ {2'b0, working_sec};

  always_ff @(posedge clk) begin
    if (load_evt) begin
      frame_buf[0] <= FRAME_HDR;
      frame_buf[1] <= TYPE_EVENT;
      frame_buf[2] <= evt_code_q;
      frame_buf[3] <= TYPE_EVENT ^ evt_code_q;
    end else if (load_sts) begin
      frame_buf[0] <= FRAME_HDR;
      frame_buf[1] <= TYPE_STATUS;
      frame_buf[2] <= {5'b0, state};
      frame_buf[3] <= {2'b0, current_hour};
      frame_buf[4] <= {2'b0, current_min};
      frame_buf[5] <= {2'b0, current_sec};
      frame_buf[6] <= {2'b0, working_hour};
      frame_buf[7] <= {2'b0, working_min};
      frame_buf[8] <= {2'b0, working_sec};
      frame_buf[9] <= sts_chk;
    end
  end

  uart_byte_tx #(
    .DIVISOR(DIVISOR)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_start(byte_start),
    .byte_data (frame_buf[idx]),
    .byte_done (byte_done),
    .tx        (tx)
  );

endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench: a line decoder pops expected bytes built by a frame model.
module tb_uart_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] state = '0;
  logic [5:0] current_hour = '0, current_min = '0, current_sec = '0;
  logic [5:0] working_hour = '0, working_min = '0, working_sec = '0;
  logic       evt_req = 1'b0;
  logic [7:0] evt_code = '0;
  logic       tx, busy, frame_done, evt_drop;

  int checks = 0, errors = 0;
  int fd_cnt = 0, drop_cnt = 0, exp_fd = 0, exp_drop = 0;
  logic [7:0] exp_q[$];

  localparam int BYTE_CYC = 10 * 10 + 2;

  always #5 clk = ~clk;

  uart_frame_sched #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000),
    .PERIOD_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .state(state),
    .current_hour(current_hour), .current_min(current_min), .current_sec(current_sec),
    .working_hour(working_hour), .working_min(working_min), .working_sec(working_sec),
    .evt_req(evt_req), .evt_code(evt_code),
    .tx(tx), .busy(busy), .frame_done(frame_done), .evt_drop(evt_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame model: header, body, XOR of body
  task automatic push_frame(input logic [7:0] body [8], input int n);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(body[i]);
      x = x ^ body[i];
    end
    exp_q.push_back(x);
    exp_fd++;
  endtask

  task automatic push_status();
    logic [7:0] b [8];
    b = '{8'h01, 8'(state), 8'(current_hour), 8'(current_min), 8'(current_sec),
          8'(working_hour), 8'(working_min), 8'(working_sec)};
    push_frame(b, 8);
  endtask

  task automatic push_event(input logic [7:0] code);
    logic [7:0] b [8];
    b = '{8'h02, code, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(b, 2);
  endtask

  task automatic rand_payload();
    state        = 3'($urandom_range(0, 7));
    current_hour = 6'($urandom_range(0, 23));
    current_min  = 6'($urandom_range(0, 59));
    current_sec  = 6'($urandom_range(0, 59));
    working_hour = 6'($urandom_range(0, 63));
    working_min  = 6'($urandom_range(0, 59));
    working_sec  = 6'($urandom_range(0, 59));
  endtask

  task automatic send_evt(input logic [7:0] code);
    evt_code = code;
    evt_req  = 1'b1;
    @(negedge clk);
    evt_req  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < limit);
    chk({name, "_frame_done_seen"}, frame_done, 1'b1);
  endtask

  task automatic wait_busy(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < limit);
    chk({name, "_busy_seen"}, busy, 1'b1);
  endtask

  task automatic status_once(input string name);
    int n;
    push_status();
    en = 1'b1;
    wait_busy(name, 1100);
    en = 1'b0;
    wait_done(name, 1200, n);
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (evt_drop === 1'b1) drop_cnt++;
  end

  // Line decoder: samples mid-bit, discards any byte overlapped by reset
  initial begin : rx_mon
    logic prev, bad;
    logic [7:0] b, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && tx === 1'b0) begin
        bad = 1'b0;
        repeat (5) @(negedge clk);
        if (!rst_n || tx !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = tx;
          if (!rst_n) bad = 1'b1;
        end
        repeat (10) @(negedge clk);
        if (!rst_n) bad = 1'b1;
        if (!bad) begin
          chk("stop_bit", tx, 1'b1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL line_byte: got %02h expected %02h", b, e);
            end
          end
        end
      end
      prev = tx;
    end
  end

  initial begin : stim
    int n;
    int fd0;
    logic [7:0] code;
    logic [5:0] old_sec;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_evt_drop", evt_drop, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed status frame, with latency from en to first start bit
    state = 3'd3; current_hour = 6'd12; current_min = 6'd34; current_sec = 6'd56;
    working_hour = 6'd1; working_min = 6'd2; working_sec = 6'd3;
    push_status();
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx === 1'b1 && n < 2000);
    en = 1'b0;
    chk("status_latency", n, 1003);
    wait_done("status_directed", 1200, n);
    chk("status_busy_fall", busy, 1'b0);
    repeat (10) @(negedge clk);

    // Directed event frame, start bit 4 edges after the request edge
    push_event(8'h5A);
    evt_code = 8'h5A;
    evt_req  = 1'b1;
    @(negedge clk);
    evt_req = 1'b0;
    n = 1;
    while (tx === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("event_latency", n, 4);
    wait_done("event_directed", 500, n);
    repeat (10) @(negedge clk);

    // Event on the same edge as a period wrap: event first, status back-to-back
    rand_payload();
    code = 8'h11;
    push_event(code);
    push_status();
    en = 1'b1;
    repeat (999) @(negedge clk);
    evt_code = code;
    evt_req  = 1'b1;
    @(negedge clk);
    evt_req = 1'b0;
    wait_done("wrap_event", 500, n);
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_done("wrap_status", 1200, n);
    chk("back_to_back_gap", n + 5, 2 + 10 * BYTE_CYC);
    repeat (10) @(negedge clk);

    // Two requests during a status frame: first queued, second dropped
    rand_payload();
    push_status();
    push_event(8'h21);
    en = 1'b1;
    wait_busy("drop", 1100);
    en = 1'b0;
    repeat (200) @(negedge clk);
    send_evt(8'h21);
    repeat (50) @(negedge clk);
    send_evt(8'h22);
    exp_drop++;
    wait_done("drop_status", 1200, n);
    wait_done("drop_event", 500, n);
    chk("drop_count", drop_cnt, exp_drop);
    repeat (10) @(negedge clk);

    // Snapshot: payload change mid-frame only affects the following frame
    rand_payload();
    push_status();
    en = 1'b1;
    wait_busy("snap", 1100);
    en = 1'b0;
    repeat (3 * BYTE_CYC + 20) @(negedge clk);
    old_sec = current_sec;
    current_sec = (old_sec == 6'd59) ? 6'd0 : old_sec + 6'd1;
    wait_done("snap_first", 1200, n);
    status_once("snap_second");
    repeat (10) @(negedge clk);

    // Randomized mix of single frames
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        code = 8'($urandom);
        push_event(code);
        send_evt(code);
        wait_done("rand_event", 500, n);
      end else begin
        rand_payload();
        status_once("rand_status");
      end
      repeat ($urandom_range(2, 40)) @(negedge clk);
    end
    chk("frame_count", fd_cnt, exp_fd);

    // Reset in the middle of the first byte abandons the frame
    send_evt(8'h77);
    n = 0;
    while (tx === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("midreset_no_frame_done", fd_cnt, fd0);
    chk("midreset_idle_tx", tx, 1'b1);

    chk("queue_empty", exp_q.size(), 0);
    chk("final_drop_count", drop_cnt, exp_drop);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
